tens_counter6: RTL
==================

# tens_counter6

Tens-digit stage of the seconds counter, directly downstream of the units (mod-10) counter. Consumes the units counter's overflow pulse, counts occurrences modulo MAX+1 (0..5 by default) as a BCD digit, and emits a one-cycle wrap pulse to the minutes stage. Provides synchronous clear, hold and preset-load for time setting.

## Interface
Parameters:
- MAX, 5, terminal count; digit counts 0..MAX, then wraps to 0 (legal 1..9)
- DW, 4, digit output width (BCD nibble)

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- carry_in  in  1  overflow pulse from the units counter; level, one or more cycles wide
- clr  in  1  synchronous clear of digit to 0
- hold  in  1  freeze counting; carry edges seen while high are dropped
- load  in  1  synchronous preset strobe
- load_val  in  DW  preset value
- tens  out  DW  current digit, registered
- wrap  out  1  one-cycle pulse, registered, on MAX->0 increment
- at_max  out  1  combinational, tens == MAX
- load_err  out  1  one-cycle pulse, registered, on rejected load

## Operation
- Rising-edge detect on carry_in: inc = carry_s & ~carry_q, where carry_q is carry_s delayed one clk. A pulse of any width counts exactly once.
- carry_s is carry_in directly (default) or the output of a 2-flop synchronizer (see Configuration).
- Priority per edge: rst > clr > load > inc (if !hold).
- clr: tens <= 0. wrap, load_err = 0. Pending inc is discarded.
- load with load_val <= MAX: tens <= load_val. load_val > MAX: tens unchanged, load_err <= 1. inc in the same cycle is discarded.
- inc, hold = 0: tens < MAX -> tens + 1, wrap <= 0. tens == MAX -> tens <= 0, wrap <= 1.
- hold = 1: tens unchanged. carry_q still tracks carry_s, so a pulse that rises during hold and is still high at release is not counted.
- wrap and load_err deassert on every cycle that does not set them.
- Arithmetic on DW bits. Comparison is unsigned. tens never exceeds MAX.

## Timing
- Reset values: tens = 0, wrap = 0, load_err = 0, at_max = (MAX == 0 ? 1 : 0), carry_q = 0, sync flops = 0.
- Latency, default build: carry_in first sampled high at edge N -> tens updated at edge N. wrap is high for the cycle after edge N, coincident with tens == 0.
- Latency with synchronizer: edge N+2.
- Back-to-back: carry_in must be low for at least one sampled cycle between pulses; a steady-high input counts once.
- rst mid-pulse: after release with carry_in still high, carry_q = 0, so the first sampled edge counts. The units stage resets together with this stage, so this does not occur in-system.
- clr/load/wrap never produce wrap or load_err on the same edge as each other, except that load_err and a dropped inc coexist.

## Configuration
- TENS_CARRY_SYNC_EN defined: carry_in passes through a 2-flop synchronizer clocked by clk (reset by rst) before edge detection. Use this when the units counter is driven from a different clock. Adds 2 cycles of latency.
- Not defined: carry_in feeds the edge detector directly. Zero added latency. carry_in must be synchronous to clk.

## Structure
- Shared package counter_pkg holds:
  - localparams SEC_TENS_MAX = 5, MIN_TENS_MAX = 5 and HR_TENS_MAX = 2
  - BCD_W = 4
- One sub-module, rise_detect: optional synchronizer, carry_q register and inc output. It takes the same macro and is reusable by the minutes and hours stages.
- The top level holds the priority mux, digit register and output flags.

## Test plan
- Reset: assert rst asynchronously mid-cycle -> tens = 0, wrap = 0, load_err = 0 immediately, with no clock required.
- Count/wrap: 6 single-cycle carry_in pulses from 0 -> tens 1,2,3,4,5,0. wrap is high for exactly one cycle when tens becomes 0. at_max is high while tens = 5.
- Wide pulse: carry_in held high 5 cycles -> tens increments by exactly 1. Low 1 cycle then high again -> increments once more.
- Hold: hold = 1 across 3 pulses -> tens unchanged. carry_in rises during hold and stays high past hold release -> no increment.
- Load/clr priority: at tens = 2, load = 1, load_val = 4, with a carry edge on the same cycle -> tens = 4. load_val = 7 -> tens stays 4 and load_err pulses once. clr and load together -> tens = 0.
- With TENS_CARRY_SYNC_EN: a single pulse at edge N -> tens changes at edge N+2. Count/wrap sequence as above.

Source files
------------

// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared constants for the BCD time-counter stages
//
// Purpose: terminal counts and digit width shared by the seconds, minutes
// and hours digit stages.
// Ports: none (package).

package counter_pkg;

  // Terminal counts of the tens digits (digit runs 0..MAX).
  localparam int SEC_TENS_MAX = 5;
  localparam int MIN_TENS_MAX = 5;
  localparam int HR_TENS_MAX  = 2;

  // Width of one BCD digit.
  localparam int BCD_W = 4;

endpackage

// File: rtl/tens_counter6_rise_detect.sv
// rtl/tens_counter6_rise_detect.sv - rising-edge detector with optional 2-flop synchronizer
//
// Purpose: turns a carry level of any width into a single-cycle increment
// request. Reused by the minutes and hours stages.
// Build option: define TENS_CARRY_SYNC_EN to pass din through a 2-flop
// synchronizer before edge detection (adds 2 cycles of latency).
// Ports:
//   clk  in   clock
//   rst  in   asynchronous, active-high reset
//   din  in   carry level from the upstream stage
//   inc  out  combinational one-cycle pulse on a rising edge of the
//             (optionally synchronized) carry

module rise_detect (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic inc
);

  logic carry_s;
  logic carry_q;

`ifdef TENS_CARRY_SYNC_EN
  logic sync1;
  logic sync2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
    end
  end

  assign carry_s = sync2;
`else
  // Caller guarantees din is already synchronous to clk.
  assign carry_s = din;
`endif

  // carry_q clears on reset so a carry still high at release counts once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      carry_q <= 1'b0;
    end else begin
      carry_q <= carry_s;
    end
  end

  assign inc = carry_s & ~carry_q;

endmodule

// File: rtl/tens_counter6.sv
// rtl/tens_counter6.sv - tens digit of the seconds counter (BCD, 0..MAX)
//
// Purpose: counts rising edges of the units-stage carry modulo MAX+1, with
// synchronous clear, hold and preset-load, and emits a one-cycle wrap pulse
// to the minutes stage.
// Build option: TENS_CARRY_SYNC_EN (forwarded to rise_detect) synchronizes
// carry_in before edge detection.
// Ports:
//   clk       in   clock, rising edge
//   rst       in   asynchronous, active-high reset
//   carry_in  in   units-stage overflow level (counted once per rising edge)
//   clr       in   synchronous clear to 0
//   hold      in   freeze counting; edges seen while high are dropped
//   load      in   synchronous preset strobe
//   load_val  in   preset value, accepted only if <= MAX
//   tens      out  current digit, registered
//   wrap      out  one-cycle pulse, registered, on MAX->0 increment
//   at_max    out  combinational, tens == MAX
//   load_err  out  one-cycle pulse, registered, on a rejected load

module tens_counter6
  import counter_pkg::*;
#(
  parameter int MAX = SEC_TENS_MAX,
  parameter int DW  = BCD_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          carry_in,
  input  logic          clr,
  input  logic          hold,
  input  logic          load,
  input  logic [DW-1:0] load_val,
  output logic [DW-1:0] tens,
  output logic          wrap,
  output logic          load_err,
  output logic          at_max
);

  localparam logic [DW-1:0] MAX_V = DW'(MAX);
  localparam logic [DW-1:0] ONE_V = DW'(1);

  logic inc;

  rise_detect u_rise_detect (
    .clk (clk),
    .rst (rst),
    .din (carry_in),
    .inc (inc)
  );

  // Priority: clr > load > inc. The edge detector keeps tracking carry_in
  // regardless, so an edge swallowed by clr/load/hold is lost, not deferred.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tens     <= '0;
      wrap     <= 1'b0;
      load_err <= 1'b0;
    end else begin
      wrap     <= 1'b0;
      load_err <= 1'b0;
      if (clr) begin
        tens <= '0;
      end else if (load) begin
        if (load_val <= MAX_V) begin
          tens <= load_val;
        end else begin
          load_err <= 1'b1;
        end
      end else if (inc && !hold) begin
        if (tens == MAX_V) begin
          tens <= '0;
          wrap <= 1'b1;
        end else begin
          tens <= tens + ONE_V;
        end
      end
    end
  end

  assign at_max = (tens == MAX_V);

endmodule
